// File: rtl/core_bus_arbiter_if.sv
// Bus bundle between the fetch/data masters, the arbiter and the single memory port.
// The master modport is the arbiter's view: it masters the memory port and serves both request channels.
interface core_bus_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic            i_valid;
    logic [AW-1:0]   i_addr;
    logic            i_ready;
    logic [DW-1:0]   i_rdata;

    logic            d_valid;
    logic [AW-1:0]   d_addr;
    logic            d_wen;
    logic [DW-1:0]   d_wdata;
    logic [DW/8-1:0] d_wstrb;
    logic            d_ready;
    logic [DW-1:0]   d_rdata;

    logic            s_valid;
    logic [AW-1:0]   s_addr;
    logic            s_wen;
    logic [DW-1:0]   s_wdata;
    logic [DW/8-1:0] s_wstrb;
    logic            s_ready;
    logic [DW-1:0]   s_rdata;

    logic [1:0]      grant;

    modport master (
        input  i_valid, i_addr,
        output i_ready, i_rdata,
        input  d_valid, d_addr, d_wen, d_wdata, d_wstrb,
        output d_ready, d_rdata,
        output s_valid, s_addr, s_wen, s_wdata, s_wstrb,
        input  s_ready, s_rdata,
        output grant
    );

    modport slave (
        output i_valid, i_addr,
        input  i_ready, i_rdata,
        output d_valid, d_addr, d_wen, d_wdata, d_wstrb,
        input  d_ready, d_rdata,
        input  s_valid, s_addr, s_wen, s_wdata, s_wstrb,
        output s_ready, s_rdata,
        input  grant
    );
endinterface

// File: rtl/core_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction in flight.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module core_bus_arbiter #(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst,
    core_bus_arbiter_if.master  bus
);
    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t          st;
    state_t          nxt;
    logic [3:0]      starve;
    logic [1:0]      grant_q;
    logic            arb;
    logic            ei;
    logic            ed;
    logic [AW-1:0]   addr_mux;
    logic            wen_mux;
    logic [DW-1:0]   wdata_mux;
    logic [DW/8-1:0] wstrb_mux;

    // The master whose transaction completes this cycle is masked, so it re-arbitrates from IDLE.
    always_comb begin
        arb = (st == IDLE) | bus.s_ready;
        ei  = bus.i_valid & ~((st == GNT_I) & bus.s_ready);
        ed  = bus.d_valid & ~((st == GNT_D) & bus.s_ready);
        if (ed && ei && (starve >= LIMIT)) nxt = GNT_I;
        else if (ed)                       nxt = GNT_D;
        else if (ei)                       nxt = GNT_I;
        else                               nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= IDLE;
            starve  <= '0;
            grant_q <= '0;
        end else if (arb) begin
            st      <= nxt;
            grant_q <= {nxt == GNT_D, nxt == GNT_I};
            if (nxt == GNT_I)
                starve <= '0;
            else if ((nxt == GNT_D) && ei && (starve != 4'hF))
                starve <= starve + 4'd1;
        end
    end

    always_comb begin
        addr_mux  = '0;
        wen_mux   = 1'b0;
        wdata_mux = '0;
        wstrb_mux = '0;
        if (grant_q[1]) begin
            addr_mux  = bus.d_addr;
            wen_mux   = bus.d_wen;
            wdata_mux = bus.d_wdata;
            wstrb_mux = bus.d_wstrb;
        end else if (grant_q[0]) begin
            addr_mux  = bus.i_addr;
        end
    end

    assign bus.s_valid = |grant_q;
    assign bus.s_addr  = addr_mux;
    assign bus.s_wen   = wen_mux;
    assign bus.s_wdata = wdata_mux;
    assign bus.s_wstrb = wstrb_mux;
    assign bus.grant   = grant_q;

    assign bus.i_ready = bus.s_ready & grant_q[0];
    assign bus.d_ready = bus.s_ready & grant_q[1];
    assign bus.i_rdata = bus.s_rdata;
    assign bus.d_rdata = bus.s_rdata;

    a_fetch_holds_valid: assert property (@(posedge clk) disable iff (!rst)
        (st == GNT_I) |-> bus.i_valid)
        else $error("fetch master dropped i_valid while granted");

    a_data_holds_valid: assert property (@(posedge clk) disable iff (!rst)
        (st == GNT_D) |-> bus.d_valid)
        else $error("data master dropped d_valid while granted");
endmodule
